// File: rtl/key_to_bin_if.sv
// Keypad/result bundle for key_to_bin. A key is consumed on a rising edge where
// key_valid is high and the block is in entry; there is no back-pressure, busy is advisory.
interface key_to_bin_if;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] disp_data;
  logic        seg_sign;
  logic [15:0] bin_data;
  logic        bin_valid;
  logic        busy;
  logic [1:0]  state_dbg;

  modport master (
    output key_valid, key_code,
    input  disp_data, seg_sign, bin_data, bin_valid, busy, state_dbg
  );

  modport slave (
    input  key_valid, key_code,
    output disp_data, seg_sign, bin_data, bin_valid, busy, state_dbg
  );
endinterface

// File: rtl/key_to_bin.sv
// Keypad BCD entry with sign, converted to a 16-bit two's-complement operand
// by a four-cycle multiply-by-ten shift-add loop.
module key_to_bin #(
  parameter int MAX_DIGITS = 4
) (
  input logic         clk,
  input logic         rst,
  key_to_bin_if.slave bus
);

  typedef enum logic [1:0] {ENTRY = 2'd0, CONV = 2'd1, OUT = 2'd2} state_t;

  localparam logic [2:0] MAX_CNT = 3'(MAX_DIGITS);

  state_t      state, state_nxt;
  logic [15:0] disp_q, disp_nxt;
  logic        sign_q, sign_nxt;
  logic [2:0]  count_q, count_nxt;
  logic        fresh_q, fresh_nxt;
  logic [13:0] acc_q, acc_nxt;
  logic [1:0]  idx_q, idx_nxt;
  logic [15:0] bin_q, bin_nxt;
  logic [3:0]  cur_digit;
  logic [13:0] acc_step;

  assign cur_digit = disp_q[{idx_q, 2'b00} +: 4];
  assign acc_step  = (acc_q << 3) + (acc_q << 1) + {10'd0, cur_digit};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ENTRY;
      disp_q  <= '0;
      sign_q  <= 1'b0;
      count_q <= '0;
      fresh_q <= 1'b0;
      acc_q   <= '0;
      idx_q   <= '0;
      bin_q   <= '0;
    end else begin
      state   <= state_nxt;
      disp_q  <= disp_nxt;
      sign_q  <= sign_nxt;
      count_q <= count_nxt;
      fresh_q <= fresh_nxt;
      acc_q   <= acc_nxt;
      idx_q   <= idx_nxt;
      bin_q   <= bin_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    disp_nxt  = disp_q;
    sign_nxt  = sign_q;
    count_nxt = count_q;
    fresh_nxt = fresh_q;
    acc_nxt   = acc_q;
    idx_nxt   = idx_q;
    bin_nxt   = bin_q;
    case (state)
      ENTRY: begin
        if (bus.key_valid) begin
          case (bus.key_code)
            4'hA: begin
              disp_nxt  = '0;
              count_nxt = '0;
              sign_nxt  = 1'b0;
              fresh_nxt = 1'b0;
            end
            4'hB: sign_nxt = ~sign_q;
            4'hC: begin
              state_nxt = CONV;
              acc_nxt   = '0;
              idx_nxt   = 2'd3;
            end
            default: begin
              if (bus.key_code <= 4'h9) begin
                // A finished result stays on display until the next digit restarts entry.
                if (fresh_q) begin
                  fresh_nxt = 1'b0;
                  disp_nxt  = {12'h000, bus.key_code};
                  count_nxt = (bus.key_code == 4'h0) ? 3'd0 : 3'd1;
                end else if (count_q < MAX_CNT &&
                             !(count_q == 3'd0 && bus.key_code == 4'h0)) begin
                  disp_nxt  = {disp_q[11:0], bus.key_code};
                  count_nxt = count_q + 3'd1;
                end
              end
            end
          endcase
        end
      end
      CONV: begin
        acc_nxt = acc_step;
        idx_nxt = idx_q - 2'd1;
        if (idx_q == 2'd0) begin
          state_nxt = OUT;
          bin_nxt   = sign_q ? (~{2'b00, acc_step} + 16'd1) : {2'b00, acc_step};
        end
      end
      OUT: begin
        state_nxt = ENTRY;
        fresh_nxt = 1'b1;
      end
      default: state_nxt = ENTRY;
    endcase
  end

  // bin_data is loaded on the edge into OUT so it is stable while bin_valid is high.
  assign bus.disp_data = disp_q;
  assign bus.seg_sign  = sign_q;
  assign bus.bin_data  = bin_q;
  assign bus.bin_valid = (state == OUT);
  assign bus.busy      = (state != ENTRY);
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_key_to_bin.sv
// Directed bench for key_to_bin: keys are driven and outputs sampled on the
// falling edge, with hand-computed expected values.
module tb_key_to_bin;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  key_to_bin_if bus ();

  key_to_bin #(.MAX_DIGITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; the key is sampled on the following rising edge.
  task automatic press(input logic [3:0] code);
    bus.key_valid = 1'b1;
    bus.key_code  = code;
    @(negedge clk);
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
  endtask

  task automatic enter_and_check(input string tag, input logic [15:0] exp_bin);
    press(4'hC);
    check({tag, "_busy1"}, {15'd0, bus.busy}, 16'd1);
    check({tag, "_vld1"}, {15'd0, bus.bin_valid}, 16'd0);
    for (int i = 2; i <= 5; i++) begin
      @(negedge clk);
      check({tag, "_busy"}, {15'd0, bus.busy}, 16'd1);
      check({tag, "_vld"}, {15'd0, bus.bin_valid}, (i == 5) ? 16'd1 : 16'd0);
    end
    check({tag, "_bin"}, bus.bin_data, exp_bin);
    @(negedge clk);
    check({tag, "_busy_end"}, {15'd0, bus.busy}, 16'd0);
    check({tag, "_vld_end"}, {15'd0, bus.bin_valid}, 16'd0);
  endtask

  initial begin
    logic found;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
    repeat (2) @(negedge clk);
    check("rst_disp", bus.disp_data, 16'h0000);
    check("rst_bin", bus.bin_data, 16'h0000);
    check("rst_flags", {12'd0, bus.seg_sign, bus.bin_valid, bus.busy, 1'b0}, 16'h0000);
    rst = 1'b0;
    @(negedge clk);

    // 1234 -> 0x04D2
    press(4'h1); press(4'h2); press(4'h3); press(4'h4);
    check("entry_1234", bus.disp_data, 16'h1234);
    enter_and_check("conv_1234", 16'h04D2);
    press(4'hA);
    check("clear_disp", bus.disp_data, 16'h0000);
    check("clear_keeps_bin", bus.bin_data, 16'h04D2);

    // -9999, with a fifth digit dropped
    press(4'h9); press(4'h9); press(4'h9); press(4'h9); press(4'h5);
    check("overflow_drop", bus.disp_data, 16'h9999);
    press(4'hB);
    check("sign_set", {15'd0, bus.seg_sign}, 16'd1);
    enter_and_check("conv_neg9999", 16'hD8F1);
    check("sign_held", {15'd0, bus.seg_sign}, 16'd1);

    // leading zeros
    press(4'hA); press(4'h0); press(4'h0); press(4'h7);
    check("lead_zero", bus.disp_data, 16'h0007);
    enter_and_check("conv_7", 16'h0007);

    // negative zero with no digits entered
    press(4'hA); press(4'hB);
    enter_and_check("conv_negzero", 16'h0000);
    check("negzero_sign", {15'd0, bus.seg_sign}, 16'd1);

    // keys during busy are ignored, then a fresh digit restarts entry
    press(4'hA); press(4'h1); press(4'h2);
    press(4'hC); press(4'h5); press(4'hA);
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      if (bus.bin_valid) found = 1'b1;
      else @(negedge clk);
    end
    check("busy_done", {15'd0, found}, 16'd1);
    check("busy_bin", bus.bin_data, 16'h000C);
    check("busy_disp", bus.disp_data, 16'h0012);
    @(negedge clk);
    press(4'h3);
    check("fresh_digit", bus.disp_data, 16'h0003);

    // reset two cycles after enter aborts the conversion
    press(4'hA); press(4'h8); press(4'hC);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("abort_bin", bus.bin_data, 16'h0000);
    check("abort_disp", bus.disp_data, 16'h0000);
    check("abort_flags", {12'd0, bus.seg_sign, bus.bin_valid, bus.busy, 1'b0}, 16'h0000);
    rst = 1'b0;
    press(4'h4);
    check("first_key_after_rst", bus.disp_data, 16'h0004);
    check("no_late_valid", {15'd0, bus.bin_valid}, 16'd0);
    press(4'h2);
    enter_and_check("conv_42", 16'h002A);

    // ignored codes
    press(4'hA);
    press(4'hE); press(4'h1); press(4'hF); press(4'h5); press(4'hD);
    check("ignored_codes", bus.disp_data, 16'h0015);
    check("ignored_state", {14'd0, bus.state_dbg}, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/key_to_bin.md
KEY_TO_BIN -- requirements
Module: key_to_bin

Interface
REQ-001 SHALL have parameter MAX_DIGITS, default 4, maximum decimal digits accepted (legal range 1..4).
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port key_valid  input  1  one-cycle strobe qualifying key_code.
REQ-005 SHALL have port key_code  input  4  4'h0-4'h9 digit, 4'hA clear, 4'hB sign toggle, 4'hC enter; 4'hD-4'hF ignored.
REQ-006 SHALL have port disp_data  output  16  four packed BCD digits being entered, [15:12] most significant.
REQ-007 SHALL have port seg_sign  output  1  1 = entered operand negative.
REQ-008 SHALL have port bin_data  output  16  converted two's-complement operand.
REQ-009 SHALL have port bin_valid  output  1  one-cycle pulse marking bin_data updated.
REQ-010 SHALL have port busy  output  1  high while converting; keys are ignored.

Function
REQ-011 SHALL implement FSM states ENTRY, CONV, OUT; ENTRY is the only state that accepts keys.
REQ-012 In ENTRY, a digit with digit count < MAX_DIGITS SHALL shift in: disp_data <= {disp_data[11:0], digit}, count+1.
REQ-013 Leading zero (count==0, digit 0) SHALL leave disp_data 0 and count 0.
REQ-014 A digit with count == MAX_DIGITS SHALL be dropped; no state change.
REQ-015 Clear SHALL set disp_data=0, count=0, seg_sign=0; bin_data is unchanged.
REQ-016 Sign toggle SHALL invert seg_sign; digits unaffected.
REQ-017 Enter SHALL move ENTRY->CONV, load acc=0 and digit index=3 (selects [15:12]); busy=1 from the next cycle.
REQ-018 In CONV, each cycle SHALL compute acc <= acc*10 + disp_data digit[index] (shift-add, 14-bit acc suffices) and decrement index; after index 0 go to OUT (exactly 4 CONV cycles).
REQ-019 In OUT, bin_data SHALL be loaded with acc if seg_sign=0, else (~acc+1) truncated to 16 bits; bin_valid=1 for that one cycle; next state ENTRY.
REQ-020 Latency: enter strobe sampled at edge N -> bin_valid high during cycle N+5, busy high during cycles N+1..N+5.
REQ-021 Negative zero SHALL yield bin_data 16'h0000; seg_sign is not altered by conversion.
REQ-022 After OUT, disp_data and seg_sign SHALL be held; a "fresh" flag is set, and the next digit key first clears disp_data/count then shifts in (sign toggle/clear/enter keep normal behaviour and clear fresh only on digit or clear).
REQ-023 Enter with count==0 SHALL convert to 0 with normal latency.
REQ-024 key_valid during CONV/OUT SHALL be ignored entirely, including clear.
REQ-025 key_valid with key_code 4'hD-4'hF SHALL have no effect in any state.
REQ-026 Non-BCD digit fields cannot arise internally; no range check on disp_data is required.

Reset
REQ-027 rst high SHALL immediately force state ENTRY, disp_data=0, seg_sign=0, bin_data=0, bin_valid=0, busy=0, count=0, fresh=0, acc=0.
REQ-028 rst asserted mid-CONV SHALL abort conversion with no bin_valid pulse and bin_data=0.
REQ-029 First key after rst deassertion SHALL be honoured on the first rising edge with rst low.

Verification
REQ-030 Keys 1,2,3,4,enter -> disp_data 16'h1234, bin_valid 5 cycles after enter, bin_data 16'h04D2.
REQ-031 Keys 9,9,9,9,sign,enter -> seg_sign 1, bin_data 16'hD8F1 (-9999); fifth digit 5 before enter leaves disp_data 16'h9999.
REQ-032 Keys 0,0,7,enter -> disp_data 16'h0007, bin_data 16'h0007; sign,enter with no digits -> bin_data 16'h0000.
REQ-033 Enter then digit 5 and clear during busy -> both ignored, bin_data reflects prior entry; digit 3 after OUT -> disp_data 16'h0003 (fresh clear).
REQ-034 rst pulse two cycles after enter -> no bin_valid, all outputs zero, subsequent 4,2,enter -> bin_data 16'h002A.
REQ-035 Keys 4'hE, 4'hF interleaved with 1,5 -> disp_data 16'h0015 only.
